// File: rtl/dsss_pkg.sv
// -----------------------------------------------------------------------------
// dsss_pkg
// Shared constants and types for the DSSS BPSK chain:
//   - CHIPS_PER_BIT       : chips per data bit, equal to the PN period
//   - LFSR_SEED/LFSR_TAPS : 4-bit PN generator seed and feedback taps
//   - SINE_LUT            : 32-entry reference, round(127*sin(2*pi*k/32))
//   - state_t             : receiver FSM states
//   - lfsr_feedback()     : feedback bit for the PN LFSR
// -----------------------------------------------------------------------------
package dsss_pkg;

  localparam int CHIPS_PER_BIT = 15;

  localparam logic [3:0] LFSR_SEED = 4'b1111;
  // Feedback is lfsr[3] ^ lfsr[2].
  localparam logic [3:0] LFSR_TAPS = 4'b1100;

  localparam logic signed [7:0] SINE_LUT [32] = '{
       8'sd0,   8'sd25,   8'sd49,   8'sd71,   8'sd90,  8'sd106,  8'sd117,  8'sd125,
     8'sd127,  8'sd125,  8'sd117,  8'sd106,   8'sd90,   8'sd71,   8'sd49,   8'sd25,
       8'sd0,  -8'sd25,  -8'sd49,  -8'sd71,  -8'sd90, -8'sd106, -8'sd117, -8'sd125,
    -8'sd127, -8'sd125, -8'sd117, -8'sd106,  -8'sd90,  -8'sd71,  -8'sd49,  -8'sd25
  };

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_t;

  function automatic logic lfsr_feedback(input logic [3:0] state);
    return ^(state & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/pn_lfsr_gen.sv
// -----------------------------------------------------------------------------
// pn_lfsr_gen
// 4-bit Fibonacci LFSR producing the 15-chip PN sequence. Shared with the
// transmit side.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, loads the seed
//   load : reload the seed (takes priority over step)
//   step : advance one chip
//   pn   : current PN chip, lfsr[0]
// -----------------------------------------------------------------------------
module pn_lfsr_gen
  import dsss_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic step,
  output logic pn
);

  logic [3:0] lfsr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      lfsr <= LFSR_SEED;
    end else if (step) begin
      lfsr <= {lfsr[2:0], lfsr_feedback(lfsr)};
    end
  end

  assign pn = lfsr[0];

endmodule

// File: rtl/dsss_bpsk_despreader.sv
// -----------------------------------------------------------------------------
// dsss_bpsk_despreader
// Coherent BPSK chip correlator followed by a 15-chip PN despreader. Each
// accepted sample is multiplied by a 32-entry sine reference, accumulated over
// SAMPLES_PER_CHIP samples into a hard chip decision, XORed with the PN chip
// and combined over 15 chips into one data bit.
//
// Pipeline: stage 1 registers the product, stage 2 accumulates and emits the
// chip, stage 3 despreads and emits the bit (one cycle after the last chip).
//
// Build option: `DSSS_SOFT_COMBINE_EN selects a signed soft sum of the chip
// correlations for the bit decision; by default a hard majority vote is used.
//
// Parameters:
//   SAMPLES_PER_CHIP : samples per chip (>= 2)
//   ACC_W            : accumulator width, >= 16 + clog2(SAMPLES_PER_CHIP)
// Ports:
//   clk          : sample clock, rising edge
//   rst          : synchronous active-high reset
//   start        : frame alignment pulse; next valid sample is sample 0
//   sample_valid : qualifies sample
//   sample       : signed 8-bit received sample
//   chip_out     : hard chip decision, held between pulses
//   chip_valid   : one-cycle pulse per chip
//   bit_out      : recovered data bit, held between pulses
//   bit_valid    : one-cycle pulse per bit
//   busy         : high while tracking a frame
// -----------------------------------------------------------------------------
module dsss_bpsk_despreader
  import dsss_pkg::*;
#(
  parameter int SAMPLES_PER_CHIP = 2500,
  parameter int ACC_W            = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sample_valid,
  input  logic signed [7:0] sample,
  output logic              chip_out,
  output logic              chip_valid,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              busy
);

  localparam int              SC_W    = $clog2(SAMPLES_PER_CHIP);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SAMPLES_PER_CHIP - 1);
  localparam logic [3:0]      CC_LAST = 4'(CHIPS_PER_BIT - 1);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  state_t state, state_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = TRACK;
      TRACK:   state_next = TRACK;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == TRACK);
  end

  // A sample coinciding with start belongs to no frame and is dropped.
  logic accept;
  assign accept = (state == TRACK) && sample_valid && !start;

  // ---------------------------------------------------------------------------
  // Stage 1: reference phase, sample counter, product register
  // ---------------------------------------------------------------------------
  logic [4:0]          phase;
  logic [SC_W-1:0]     sample_cnt;
  logic signed [15:0]  prod;
  logic                prod_valid;
  logic                prod_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase      <= '0;
      sample_cnt <= '0;
      prod       <= '0;
      prod_valid <= 1'b0;
      prod_last  <= 1'b0;
    end else begin
      prod_valid <= accept;
      if (start) begin
        phase      <= '0;
        sample_cnt <= '0;
      end else if (accept) begin
        prod       <= sample * SINE_LUT[phase];
        prod_last  <= (sample_cnt == SC_LAST);
        phase      <= phase + 5'd1;
        sample_cnt <= (sample_cnt == SC_LAST) ? '0 : sample_cnt + SC_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: chip correlator
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_final;
  // Set when the chip pulse now on chip_valid was finished across a start;
  // that chip must not reach the new frame's despreader.
  logic                    chip_old;

`ifdef DSSS_SOFT_COMBINE_EN
  logic signed [ACC_W-1:0] acc_chip;
`endif

  always_comb begin
    acc_final = acc + {{(ACC_W-16){prod[15]}}, prod};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      chip_out   <= 1'b0;
      chip_valid <= 1'b0;
      chip_old   <= 1'b0;
`ifdef DSSS_SOFT_COMBINE_EN
      acc_chip   <= '0;
`endif
    end else begin
      chip_valid <= prod_valid && prod_last;
      chip_old   <= start;
      if (prod_valid) begin
        if (prod_last) begin
          chip_out <= ~acc_final[ACC_W-1];
          acc      <= '0;
`ifdef DSSS_SOFT_COMBINE_EN
          acc_chip <= acc_final;
`endif
        end else begin
          acc <= acc_final;
        end
      end
      if (start) begin
        acc <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: despread and bit decision
  // ---------------------------------------------------------------------------
  logic       pn;
  logic       chip_take;
  logic       bit_end;
  logic       bit_decision;
  logic [3:0] chip_cnt;

  assign chip_take = chip_valid && !chip_old;
  assign bit_end   = chip_take && (chip_cnt == CC_LAST);

  pn_lfsr_gen u_pn (
    .clk  (clk),
    .rst  (rst),
    .load (start || bit_end),
    .step (chip_take),
    .pn   (pn)
  );

`ifdef DSSS_SOFT_COMBINE_EN
  logic signed [ACC_W+3:0] soft_sum;
  logic signed [ACC_W+3:0] soft_next;
  logic signed [ACC_W+3:0] chip_term;

  // Undo the spreading on the correlation itself: pn=1 chips were inverted.
  always_comb begin
    chip_term    = {{4{acc_chip[ACC_W-1]}}, acc_chip};
    soft_next    = pn ? (soft_sum - chip_term) : (soft_sum + chip_term);
    bit_decision = (soft_next > 0);
  end

  always_ff @(posedge clk) begin
    if (rst || start || bit_end) begin
      soft_sum <= '0;
    end else if (chip_take) begin
      soft_sum <= soft_next;
    end
  end
`else
  logic [3:0] ones;
  logic [3:0] ones_next;

  // At most 15 despread ones per bit, so 4 bits never overflow.
  always_comb begin
    ones_next    = ones + {3'b000, chip_out ^ pn};
    bit_decision = (ones_next >= 4'd8);
  end

  always_ff @(posedge clk) begin
    if (rst || start || bit_end) begin
      ones <= '0;
    end else if (chip_take) begin
      ones <= ones_next;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      chip_cnt  <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
    end else begin
      // A bit completing in the same cycle as start still fires.
      bit_valid <= bit_end;
      if (bit_end) begin
        bit_out <= bit_decision;
      end
      if (start || bit_end) begin
        chip_cnt <= '0;
      end else if (chip_take) begin
        chip_cnt <= chip_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_dsss_bpsk_despreader.sv
// -----------------------------------------------------------------------------
// tb_dsss_bpsk_despreader
// Self-checking bench for dsss_bpsk_despreader (SAMPLES_PER_CHIP=32,
// ACC_W=21). A reference model computes every chip and bit from the sample
// stream with plain integer arithmetic and queues each expected pulse with the
// cycle it is due in; a monitor compares DUT pulses against those queues.
// Honours `DSSS_SOFT_COMBINE_EN for the bit decision rule.
// -----------------------------------------------------------------------------
module tb_dsss_bpsk_despreader;

  localparam int SPC   = 32;
  localparam int ACC_W = 21;
  localparam int CPB   = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              sample_valid;
  logic signed [7:0] sample;
  logic              chip_out;
  logic              chip_valid;
  logic              bit_out;
  logic              bit_valid;
  logic              busy;

  always #5 clk = ~clk;

  dsss_bpsk_despreader #(
    .SAMPLES_PER_CHIP (SPC),
    .ACC_W            (ACC_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .sample_valid (sample_valid),
    .sample       (sample),
    .chip_out     (chip_out),
    .chip_valid   (chip_valid),
    .bit_out      (bit_out),
    .bit_valid    (bit_valid),
    .busy         (busy)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference tables, built from their mathematical definitions
  // ---------------------------------------------------------------------------
  int ref_lut [32];
  int pn_seq  [CPB];

  task automatic build_tables();
    int s;
    for (int k = 0; k < 32; k++) begin
      real r;
      r = 127.0 * $sin(2.0 * 3.14159265358979 * k / 32.0);
      ref_lut[k] = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
    end
    s = 15;
    for (int c = 0; c < CPB; c++) begin
      pn_seq[c] = s & 1;
      s = ((s << 1) & 14) | (((s >> 3) ^ (s >> 2)) & 1);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    int val;
    int due;
  } ev_t;

  ev_t    chip_q [$];
  ev_t    bit_q  [$];
  int     cyc = 0;
  bit     m_track = 1'b0;
  int     m_phase, m_sidx, m_cidx, m_ones;
  longint m_sum, m_soft;

  task automatic model_clear_frame();
    m_phase = 0; m_sidx = 0; m_cidx = 0; m_ones = 0; m_sum = 0; m_soft = 0;
  endtask

  // Drop expected pulses due after slot lim.
  task automatic purge(input int lim);
    while (chip_q.size() > 0 && chip_q[$].due > lim) void'(chip_q.pop_back());
    while (bit_q.size() > 0 && bit_q[$].due > lim) void'(bit_q.pop_back());
  endtask

  always @(posedge clk) begin
    int chipv, bitv;
    cyc++;
    if (rst) begin
      m_track = 1'b0;
      model_clear_frame();
      purge(cyc - 1);
    end else if (start) begin
      m_track = 1'b1;
      model_clear_frame();
      purge(cyc);
    end else if (m_track && sample_valid) begin
      m_sum   += longint'(int'(sample) * ref_lut[m_phase]);
      m_phase  = (m_phase + 1) % 32;
      m_sidx++;
      if (m_sidx == SPC) begin
        chipv = (m_sum >= 0) ? 1 : 0;
        chip_q.push_back('{chipv, cyc + 1});
        m_ones += chipv ^ pn_seq[m_cidx];
        m_soft += (pn_seq[m_cidx] != 0) ? -m_sum : m_sum;
        m_sum   = 0;
        m_sidx  = 0;
        m_cidx++;
        if (m_cidx == CPB) begin
`ifdef DSSS_SOFT_COMBINE_EN
          bitv = (m_soft > 0) ? 1 : 0;
`else
          bitv = (m_ones >= 8) ? 1 : 0;
`endif
          bit_q.push_back('{bitv, cyc + 2});
          m_cidx = 0; m_ones = 0; m_soft = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  int chip_vals [$];
  int bit_vals  [$];
  int bit_cyc   [$];

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("busy", busy, m_track);
      if (chip_q.size() > 0 && chip_q[0].due == cyc) begin
        check("chip_pulse", chip_valid, 1);
        check("chip_value", chip_out, chip_q[0].val);
        void'(chip_q.pop_front());
      end else if (chip_valid) begin
        check("chip_spurious", chip_valid, 0);
      end
      if (bit_q.size() > 0 && bit_q[0].due == cyc) begin
        check("bit_pulse", bit_valid, 1);
        check("bit_value", bit_out, bit_q[0].val);
        void'(bit_q.pop_front());
      end else if (bit_valid) begin
        check("bit_spurious", bit_valid, 0);
      end
      if (chip_valid) chip_vals.push_back(int'(chip_out));
      if (bit_valid) begin
        bit_vals.push_back(int'(bit_out));
        bit_cyc.push_back(cyc);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic step(input logic r, input logic st, input logic v, input logic signed [7:0] s);
    rst = r; start = st; sample_valid = v; sample = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic send_chip(input int chipv, input int nsamp, input bit gap, input bit noisy);
    for (int k = 0; k < nsamp; k++) begin
      int a;
      a = noisy ? (ref_lut[k % 32] / 2 + int'($urandom_range(40)) - 20) : ref_lut[k % 32];
      step(1'b0, 1'b0, 1'b1, 8'((chipv != 0) ? a : -a));
      if (gap) step(1'b0, 1'b0, 1'b0, 8'($urandom));
    end
  endtask

  task automatic send_bit(input int b, input int flip_mask, input bit gap, input bit noisy);
    for (int c = 0; c < CPB; c++)
      send_chip(b ^ pn_seq[c] ^ ((flip_mask >> c) & 1), SPC, gap, noisy);
  endtask

  task automatic clear_records();
    chip_vals.delete();
    bit_vals.delete();
    bit_cyc.delete();
  endtask

  task automatic check_bits(input string tag, input int exp [$]);
    check({tag, "_count"}, bit_vals.size(), exp.size());
    for (int i = 0; i < exp.size() && i < bit_vals.size(); i++)
      check(tag, bit_vals[i], exp[i]);
  endtask

  task automatic check_spacing(input string tag, input int gap_cycles);
    for (int i = 1; i < bit_cyc.size(); i++)
      check(tag, bit_cyc[i] - bit_cyc[i-1], gap_cycles);
  endtask

  initial begin
    int seq [$];
    int sent;

    build_tables();
    step(1'b1, 1'b0, 1'b0, 8'sd0);
    step(1'b1, 1'b0, 1'b0, 8'sd0);
    step(1'b1, 1'b0, 1'b0, 8'sd0);
    check("rst_chip_out",   chip_out,   0);
    check("rst_chip_valid", chip_valid, 0);
    check("rst_bit_out",    bit_out,    0);
    check("rst_bit_valid",  bit_valid,  0);
    check("rst_busy",       busy,       0);

    // Samples in IDLE produce nothing.
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b1, 8'($urandom));
    check("idle_no_chips", chip_vals.size(), 0);

    // Noiseless bit 1.
    clear_records();
    step(1'b0, 1'b1, 1'b0, 8'sd0);
    send_bit(1, 0, 1'b0, 1'b0);
    idle(4);
    check("b1_chip_count", chip_vals.size(), CPB);
    for (int c = 0; c < CPB && c < chip_vals.size(); c++)
      check("b1_chip", chip_vals[c], 1 ^ pn_seq[c]);
    seq = '{1};
    check_bits("b1_bit", seq);

    // Back-to-back 1,0,1,1,0 continuous, then with every-other-cycle valid.
    seq = '{1, 0, 1, 1, 0};
    clear_records();
    foreach (seq[i]) send_bit(seq[i], 0, 1'b0, 1'b0);
    idle(4);
    check_bits("seq_bit", seq);
    check_spacing("seq_spacing", CPB * SPC);

    clear_records();
    foreach (seq[i]) send_bit(seq[i], 0, 1'b1, 1'b0);
    idle(4);
    check_bits("gap_bit", seq);
    check_spacing("gap_spacing", 2 * CPB * SPC);

    // Bit 0 with 7 chips flipped: both combine rules give 0.
    clear_records();
    send_bit(0, 'h7F, 1'b0, 1'b0);
    idle(4);
    seq = '{0};
    check_bits("flip7_bit", seq);

    // Noisy random data with random gapping.
    clear_records();
    seq = {};
    for (int i = 0; i < 4; i++) begin
      seq.push_back(int'($urandom_range(1)));
      send_bit(seq[i], 0, 1'($urandom_range(1)), 1'b1);
    end
    idle(4);
    check_bits("noisy_bit", seq);

    // Fully random samples, ~75% valid, two bits' worth; model decides.
    sent = 0;
    while (sent < 2 * CPB * SPC) begin
      if ($urandom_range(3) != 0) begin
        step(1'b0, 1'b0, 1'b1, 8'($urandom));
        sent++;
      end else begin
        step(1'b0, 1'b0, 1'b0, 8'($urandom));
      end
    end
    idle(4);

    // start right after chip 5's last sample (that chip's pulse is one cycle
    // out), with a valid sample on the start cycle that must be dropped.
    clear_records();
    step(1'b0, 1'b1, 1'b0, 8'sd0);
    for (int c = 0; c < 6; c++) send_chip(1 ^ pn_seq[c], SPC, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'sd100);
    send_bit(0, 0, 1'b0, 1'b0);
    idle(4);
    check("restart_chip_count", chip_vals.size(), 6 + CPB);
    seq = '{0};
    check_bits("restart_bit", seq);

    // start while a bit pulse is one cycle out: that bit still fires.
    clear_records();
    send_bit(1, 0, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 1'b1, 1'b0, 8'sd0);
    send_bit(1, 0, 1'b0, 1'b0);
    idle(4);
    seq = '{1, 1};
    check_bits("start_edge_bit", seq);

    // rst at sample 17 of chip 9.
    step(1'b0, 1'b1, 1'b0, 8'sd0);
    for (int c = 0; c < 9; c++) send_chip(1 ^ pn_seq[c], SPC, 1'b0, 1'b0);
    send_chip(1 ^ pn_seq[9], 17, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'($urandom));
    check("mid_rst_chip_out",   chip_out,   0);
    check("mid_rst_chip_valid", chip_valid, 0);
    check("mid_rst_bit_out",    bit_out,    0);
    check("mid_rst_bit_valid",  bit_valid,  0);
    check("mid_rst_busy",       busy,       0);
    clear_records();
    for (int i = 0; i < 2 * SPC; i++) step(1'b0, 1'b0, 1'b1, 8'($urandom));
    idle(4);
    check("post_rst_no_chips", chip_vals.size(), 0);
    step(1'b0, 1'b1, 1'b0, 8'sd0);
    send_bit(0, 0, 1'b0, 1'b0);
    idle(4);
    seq = '{0};
    check_bits("post_rst_bit", seq);

    idle(4);
    check("chip_q_drained", chip_q.size(), 0);
    check("bit_q_drained",  bit_q.size(),  0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
